// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in serial-out transmitter.
package piso_pkg;

  typedef enum logic [0:0] {IDLE, SHIFT} piso_state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Loadable down-counter with a zero flag; stops at zero rather than wrapping.
module bit_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// MSB-first serializer: accepts an N-bit word on valid/ready and streams it out
// one bit per clock with registered sout/sout_valid/last/busy.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         last,
  output logic         busy,
  output logic         dbg_state
);

  localparam int            CW       = cnt_w(N);
  localparam logic [CW-1:0] LOAD_VAL = CW'(N - 1);

  // Handshake: a word transfers on an edge where din_valid and din_ready are
  // both 1; din_ready is combinational and may rise only in IDLE or in the
  // final-bit cycle of SHIFT, and is forced low while rst is high.

  piso_state_t   state_q, state_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic          sout_q, sout_d;
  logic          sout_valid_q, sout_valid_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic          cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0] cnt;
  logic          accept;

  bit_counter #(.W(CW)) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (LOAD_VAL),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  assign din_ready = !rst && ((state_q == IDLE) || ((state_q == SHIFT) && cnt_zero));
  assign accept    = din_valid && din_ready;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (rst) begin
      state_d = IDLE;
      shreg_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shreg_d  = din;
            cnt_load = 1'b1;
            state_d  = SHIFT;
          end
        end
        SHIFT: begin
          if (!cnt_zero) begin
            shreg_d = {shreg_q[N-2:0], 1'b0};
            cnt_dec = 1'b1;
          end else if (accept) begin
            shreg_d  = din;
            cnt_load = 1'b1;
          end else begin
            shreg_d = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered from next-state values so the MSB is on sout
  // in the very cycle after the accept edge.
  always_comb begin
    sout_d       = (state_d == SHIFT) ? shreg_d[N-1] : 1'b0;
    sout_valid_d = (state_d == SHIFT);
    busy_d       = (state_d == SHIFT);
    last_d       = cnt_dec && (cnt == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign last       = last_q;
  assign busy       = busy_q;
  assign dbg_state  = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: vector table plus random run against a bit-queue
// model on N=4, and hand sequences on N=2 and N=8 instances.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [3:0] din4 = '0;
  logic       dv4 = 1'b0;
  logic       rdy4, sout4, sv4, last4, busy4, st4;
  logic [1:0] din2 = '0;
  logic       dv2 = 1'b0;
  logic       rdy2, sout2, sv2, last2, busy2, st2;
  logic [7:0] din8 = '0;
  logic       dv8 = 1'b0;
  logic       rdy8, sout8, sv8, last8, busy8, st8;

  logic [3:0] sipo4 = '0;

  int tests = 0;
  int fails = 0;

  // clock/reset block
  always #5 clk = ~clk;

  always @(posedge clk) sipo4 <= {sipo4[2:0], sout4};

  piso_serializer #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .din(din4), .din_valid(dv4), .din_ready(rdy4),
    .sout(sout4), .sout_valid(sv4), .last(last4), .busy(busy4), .dbg_state(st4)
  );
  piso_serializer #(.N(2)) dut2 (
    .clk(clk), .rst(rst), .din(din2), .din_valid(dv2), .din_ready(rdy2),
    .sout(sout2), .sout_valid(sv2), .last(last2), .busy(busy2), .dbg_state(st2)
  );
  piso_serializer #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .din(din8), .din_valid(dv8), .din_ready(rdy8),
    .sout(sout8), .sout_valid(sv8), .last(last8), .busy(busy8), .dbg_state(st8)
  );

  typedef struct {
    logic       r;
    logic       v;
    logic [3:0] d;
    logic [4:0] exp_o;   // {sout, sout_valid, last, busy, din_ready}
    logic       chk_sipo;
    logic [3:0] exp_sipo;
  } vec_t;

  vec_t vt[35];

  // scoreboard: one entry per serial bit still owed, {bit, last}
  logic [1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic v, input logic [3:0] d,
                              input logic [4:0] o, input logic c, input logic [3:0] s);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.exp_o = o; x.chk_sipo = c; x.exp_sipo = s;
    return x;
  endfunction

  task automatic run_w2(input logic [1:0] w);
    dv2 = 1'b1; din2 = w;
    #2 check("w2_ready", {31'd0, rdy2}, 32'd1);
    tick();
    dv2 = 1'b0; din2 = '0;
    for (int j = 0; j < 2; j++) begin
      #2 check($sformatf("w2_bit%0d", j), {28'd0, sout2, sv2, last2, busy2},
               {28'd0, w[1-j], 1'b1, (j == 1), 1'b1});
      tick();
    end
    #2 check("w2_idle", {27'd0, sout2, sv2, last2, busy2, rdy2}, 32'd1);
  endtask

  task automatic run_w8(input logic [7:0] w);
    dv8 = 1'b1; din8 = w;
    #2 check("w8_ready", {31'd0, rdy8}, 32'd1);
    tick();
    dv8 = 1'b0; din8 = '0;
    for (int j = 0; j < 8; j++) begin
      #2 check($sformatf("w8_bit%0d", j), {28'd0, sout8, sv8, last8, busy8},
               {28'd0, w[7-j], 1'b1, (j == 7), 1'b1});
      tick();
    end
    #2 check("w8_idle", {27'd0, sout8, sv8, last8, busy8, rdy8}, 32'd1);
  endtask

  initial begin
    logic [4:0] exp_o;
    logic       m_ready;

    vt[0]  = mk(1, 1, 4'hF, 5'b00000, 0, 4'h0);
    vt[1]  = mk(1, 1, 4'hF, 5'b00000, 0, 4'h0);
    vt[2]  = mk(1, 1, 4'hF, 5'b00000, 0, 4'h0);
    vt[3]  = mk(0, 1, 4'hB, 5'b00001, 0, 4'h0);
    vt[4]  = mk(0, 0, 4'h0, 5'b11010, 0, 4'h0);
    vt[5]  = mk(0, 0, 4'h0, 5'b01010, 0, 4'h0);
    vt[6]  = mk(0, 0, 4'h0, 5'b11010, 0, 4'h0);
    vt[7]  = mk(0, 0, 4'h0, 5'b11111, 0, 4'h0);
    vt[8]  = mk(0, 1, 4'hA, 5'b00001, 1, 4'hB);
    vt[9]  = mk(0, 1, 4'h5, 5'b11010, 0, 4'h0);
    vt[10] = mk(0, 1, 4'h5, 5'b01010, 0, 4'h0);
    vt[11] = mk(0, 1, 4'h5, 5'b11010, 0, 4'h0);
    vt[12] = mk(0, 1, 4'h5, 5'b01111, 0, 4'h0);
    vt[13] = mk(0, 1, 4'hC, 5'b01010, 0, 4'h0);
    vt[14] = mk(0, 1, 4'hC, 5'b11010, 0, 4'h0);
    vt[15] = mk(0, 1, 4'hC, 5'b01010, 0, 4'h0);
    vt[16] = mk(0, 1, 4'hC, 5'b11111, 0, 4'h0);
    vt[17] = mk(0, 0, 4'h0, 5'b11010, 0, 4'h0);
    vt[18] = mk(0, 0, 4'h0, 5'b11010, 0, 4'h0);
    vt[19] = mk(0, 0, 4'h0, 5'b01010, 0, 4'h0);
    vt[20] = mk(0, 0, 4'h0, 5'b01111, 0, 4'h0);
    vt[21] = mk(0, 1, 4'h6, 5'b00001, 1, 4'hC);
    vt[22] = mk(0, 1, 4'hF, 5'b01010, 0, 4'h0);
    vt[23] = mk(0, 0, 4'h0, 5'b11010, 0, 4'h0);
    vt[24] = mk(0, 1, 4'h9, 5'b11010, 0, 4'h0);
    vt[25] = mk(0, 0, 4'h0, 5'b01111, 0, 4'h0);
    vt[26] = mk(0, 1, 4'hC, 5'b00001, 1, 4'h6);
    vt[27] = mk(0, 0, 4'h0, 5'b11010, 0, 4'h0);
    vt[28] = mk(1, 1, 4'h3, 5'b11010, 0, 4'h0);
    vt[29] = mk(0, 1, 4'h6, 5'b00001, 0, 4'h0);
    vt[30] = mk(0, 0, 4'h0, 5'b01010, 0, 4'h0);
    vt[31] = mk(0, 0, 4'h0, 5'b11010, 0, 4'h0);
    vt[32] = mk(0, 0, 4'h0, 5'b11010, 0, 4'h0);
    vt[33] = mk(0, 0, 4'h0, 5'b01111, 0, 4'h0);
    vt[34] = mk(0, 0, 4'h0, 5'b00001, 1, 4'h6);

    rst = 1'b1;
    tick();

    // directed vector table on N=4
    for (int i = 0; i < 35; i++) begin
      rst = vt[i].r; dv4 = vt[i].v; din4 = vt[i].d;
      #2;
      check($sformatf("vec%0d_outs", i), {27'd0, sout4, sv4, last4, busy4, rdy4},
            {27'd0, vt[i].exp_o});
      if (vt[i].chk_sipo)
        check($sformatf("vec%0d_sipo", i), {28'd0, sipo4}, {28'd0, vt[i].exp_sipo});
      tick();
    end

    // random traffic on N=4 against the bit-queue model
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      rst  = ($urandom_range(0, 39) == 0);
      dv4  = ($urandom_range(0, 2) != 0);
      din4 = 4'($urandom_range(0, 15));
      #2;
      m_ready = !rst && (exp_q.size() <= 1);
      if (exp_q.size() > 0) exp_o = {exp_q[0][1], 1'b1, exp_q[0][0], 1'b1, m_ready};
      else                  exp_o = {4'b0000, m_ready};
      check($sformatf("rand%0d", c), {27'd0, sout4, sv4, last4, busy4, rdy4}, {27'd0, exp_o});
      if (rst) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (dv4 && m_ready)
          for (int b = 3; b >= 0; b--) exp_q.push_back({din4[b], (b == 0)});
      end
      tick();
    end
    rst = 1'b0; dv4 = 1'b0;
    tick();
    tick();

    // width sweep
    run_w2(2'b10);
    tick();
    run_w2(2'b01);
    tick();
    run_w8(8'hA5);
    tick();
    run_w8(8'h3C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
